// File: rtl/fifo_wptr_full.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_wptr_full
//  Description : Write-domain pointer / full-flag generator of an async FIFO.
//                Synchronizes the read Gray pointer into w_clk, advances the
//                binary and Gray write pointers, and derives the fill level,
//                full, almost-full and overflow indications.
//  Revision    : 1.0  initial release
// ============================================================================
module fifo_wptr_full #(
  parameter int DEPTH    = 8,
  parameter int PTR_WD   = 3,
  parameter int AFULL_TH = 6
) (
  input  logic              w_clk,
  input  logic              w_rst_n,
  input  logic              w_enbl,
  input  logic [PTR_WD:0]   rd_gray_ptr,
  output logic [PTR_WD:0]   bin_wr_ptr,
  output logic [PTR_WD:0]   gray_wr_ptr,
  output logic              full_flag,
  output logic              almost_full,
  output logic [PTR_WD:0]   wr_level,
  output logic              overflow
);

  localparam logic [PTR_WD:0] c_afull_th = (PTR_WD+1)'(AFULL_TH);

  // Two-stage synchronizer for the read Gray pointer
  logic [PTR_WD:0] rq1_q, rq2_q;

  // Write-domain state registers and their next-state values
  logic [PTR_WD:0] bin_q,   bin_d;
  logic [PTR_WD:0] gray_q,  gray_d;
  logic [PTR_WD:0] level_q, level_d;
  logic            full_q,  full_d;
  logic            afull_q, afull_d;
  logic            ovf_q,   ovf_d;

  logic            wr_acc;
  logic [PTR_WD:0] rbin;
  logic [PTR_WD:0] full_cmp;

  // Bring the asynchronous read pointer into w_clk; only rq2_q is consumed
  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      rq1_q <= '0;
      rq2_q <= '0;
    end else begin
      rq1_q <= rd_gray_ptr;
      rq2_q <= rq1_q;
    end
  end

  // Next-pointer arithmetic, Gray-to-binary of the synced read pointer, flags
  always_comb begin
    wr_acc = w_enbl && !full_q;
    bin_d  = bin_q + (PTR_WD+1)'(wr_acc);
    gray_d = bin_d ^ (bin_d >> 1);

    // Each binary bit is the XOR of all Gray bits from the MSB down to it
    rbin = '0;
    for (int i = 0; i <= PTR_WD; i++) begin
      rbin[i] = ^(rq2_q >> i);
    end

    // Full when the write pointer is exactly one lap ahead of the read pointer
    full_cmp = {~rq2_q[PTR_WD:PTR_WD-1], rq2_q[PTR_WD-2:0]};
    full_d   = (gray_d == full_cmp);
    level_d  = bin_d - rbin;
    afull_d  = (level_d >= c_afull_th);
    ovf_d    = w_enbl && full_q;
  end

  // Register pointers and flags; full rises on the same edge as the last write
  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      bin_q   <= '0;
      gray_q  <= '0;
      level_q <= '0;
      full_q  <= 1'b0;
      afull_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      bin_q   <= bin_d;
      gray_q  <= gray_d;
      level_q <= level_d;
      full_q  <= full_d;
      afull_q <= afull_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bin_wr_ptr  = bin_q;
  assign gray_wr_ptr = gray_q;
  assign full_flag   = full_q;
  assign almost_full = afull_q;
  assign wr_level    = level_q;
  assign overflow    = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_fifo_wptr_full.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fifo_wptr_full
//  Description : Directed, table-driven bench for fifo_wptr_full.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fifo_wptr_full;

  localparam int DEPTH    = 8;
  localparam int PTR_WD   = 3;
  localparam int AFULL_TH = 6;

  logic          w_clk;
  logic          w_rst_n;
  logic          w_enbl;
  logic [3:0]    rd_gray_ptr;
  logic [3:0]    bin_wr_ptr;
  logic [3:0]    gray_wr_ptr;
  logic          full_flag;
  logic          almost_full;
  logic [3:0]    wr_level;
  logic          overflow;

  int checks = 0;
  int errors = 0;

  fifo_wptr_full #(
    .DEPTH    (DEPTH),
    .PTR_WD   (PTR_WD),
    .AFULL_TH (AFULL_TH)
  ) dut (
    .w_clk       (w_clk),
    .w_rst_n     (w_rst_n),
    .w_enbl      (w_enbl),
    .rd_gray_ptr (rd_gray_ptr),
    .bin_wr_ptr  (bin_wr_ptr),
    .gray_wr_ptr (gray_wr_ptr),
    .full_flag   (full_flag),
    .almost_full (almost_full),
    .wr_level    (wr_level),
    .overflow    (overflow)
  );

  initial w_clk = 1'b0;
  always #5 w_clk = ~w_clk;

  typedef struct {
    logic       en;
    logic [3:0] rd;
    logic [3:0] bin;
    logic [3:0] gray;
    logic       full;
    logic       afull;
    logic [3:0] lvl;
    logic       ovf;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic en, input logic [3:0] rd,
                              input logic [3:0] bin, input logic [3:0] gray,
                              input logic full, input logic afull,
                              input logic [3:0] lvl, input logic ovf);
    vec_t v;
    v.en = en; v.rd = rd; v.bin = bin; v.gray = gray;
    v.full = full; v.afull = afull; v.lvl = lvl; v.ovf = ovf;
    vecs.push_back(v);
  endfunction

  // Compare every output against the expected set in one go
  task automatic check_all(input string name, input logic [3:0] bin,
                           input logic [3:0] gray, input logic full,
                           input logic afull, input logic [3:0] lvl,
                           input logic ovf);
    logic [14:0] act, exp;
    act = {bin_wr_ptr, gray_wr_ptr, full_flag, almost_full, wr_level, overflow};
    exp = {bin, gray, full, afull, lvl, ovf};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got bin=%b gray=%b full=%b afull=%b lvl=%0d ovf=%b, want bin=%b gray=%b full=%b afull=%b lvl=%0d ovf=%b",
               name, bin_wr_ptr, gray_wr_ptr, full_flag, almost_full, wr_level, overflow,
               bin, gray, full, afull, lvl, ovf);
    end
  endtask

  // full_flag must mirror wr_level == DEPTH, and the level never exceeds DEPTH
  task automatic check_inv(input string name);
    checks++;
    if ((full_flag !== (wr_level == 4'(DEPTH))) || (wr_level > 4'(DEPTH))) begin
      errors++;
      $display("FAIL %s invariant: got full=%b lvl=%0d, want full==(lvl==%0d) and lvl<=%0d",
               name, full_flag, wr_level, DEPTH, DEPTH);
    end
  endtask

  task automatic step();
    @(posedge w_clk);
    #1;
  endtask

  initial begin
    logic [3:0] prev_gray;
    logic [3:0] exp_bin;
    logic [3:0] exp_lvl;
    logic [3:0] g;

    // Fill to full, overflow, drain via read pointer, simultaneous write/read
    add(1, 4'b0000, 4'd1,  4'b0001, 0, 0, 4'd1, 0);
    add(1, 4'b0000, 4'd2,  4'b0011, 0, 0, 4'd2, 0);
    add(1, 4'b0000, 4'd3,  4'b0010, 0, 0, 4'd3, 0);
    add(1, 4'b0000, 4'd4,  4'b0110, 0, 0, 4'd4, 0);
    add(1, 4'b0000, 4'd5,  4'b0111, 0, 0, 4'd5, 0);
    add(1, 4'b0000, 4'd6,  4'b0101, 0, 1, 4'd6, 0);
    add(1, 4'b0000, 4'd7,  4'b0100, 0, 1, 4'd7, 0);
    add(1, 4'b0000, 4'd8,  4'b1100, 1, 1, 4'd8, 0);
    add(1, 4'b0000, 4'd8,  4'b1100, 1, 1, 4'd8, 1);
    add(1, 4'b0000, 4'd8,  4'b1100, 1, 1, 4'd8, 1);
    add(1, 4'b0000, 4'd8,  4'b1100, 1, 1, 4'd8, 1);
    add(0, 4'b0011, 4'd8,  4'b1100, 1, 1, 4'd8, 0);
    add(0, 4'b0011, 4'd8,  4'b1100, 1, 1, 4'd8, 0);
    add(0, 4'b0011, 4'd8,  4'b1100, 0, 1, 4'd6, 0);
    add(1, 4'b0011, 4'd9,  4'b1101, 0, 1, 4'd7, 0);
    add(0, 4'b0010, 4'd9,  4'b1101, 0, 1, 4'd7, 0);
    add(0, 4'b0010, 4'd9,  4'b1101, 0, 1, 4'd7, 0);
    // read advance reaches the level register on the same edge as a write
    add(1, 4'b0010, 4'd10, 4'b1111, 0, 1, 4'd7, 0);

    // Reset state
    w_rst_n = 1'b0;
    w_enbl = 1'b0;
    rd_gray_ptr = 4'b0000;
    step();
    step();
    check_all("reset", 4'd0, 4'd0, 0, 0, 4'd0, 0);
    w_rst_n = 1'b1;
    step();
    check_all("idle", 4'd0, 4'd0, 0, 0, 4'd0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      w_enbl = vecs[i].en;
      rd_gray_ptr = vecs[i].rd;
      step();
      check_all($sformatf("vec%0d", i), vecs[i].bin, vecs[i].gray, vecs[i].full,
                vecs[i].afull, vecs[i].lvl, vecs[i].ovf);
      check_inv($sformatf("vec%0d", i));
    end

    // Asynchronous reset in the middle of a write burst
    w_enbl = 1'b1;
    step();
    #2;
    w_rst_n = 1'b0;
    #1;
    check_all("async_reset", 4'd0, 4'd0, 0, 0, 4'd0, 0);
    w_enbl = 1'b0;
    rd_gray_ptr = 4'b0000;
    step();
    w_rst_n = 1'b1;
    step();
    check_all("post_reset_idle", 4'd0, 4'd0, 0, 0, 4'd0, 0);

    // Wrap: the read side consumes each written entry; with three edges of
    // read-pointer latency the level settles at 3
    prev_gray = gray_wr_ptr;
    exp_bin = 4'd0;
    w_enbl = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      step();
      exp_bin = exp_bin + 4'd1;
      exp_lvl = (k < 3) ? 4'(k) : 4'd3;
      g = exp_bin ^ (exp_bin >> 1);
      check_all($sformatf("wrap%0d", k), exp_bin, g, 0, 0, exp_lvl, 0);
      checks++;
      if ($countones(gray_wr_ptr ^ prev_gray) != 1) begin
        errors++;
        $display("FAIL wrap%0d gray_step: got %b after %b, want exactly one bit change",
                 k, gray_wr_ptr, prev_gray);
      end
      prev_gray = gray_wr_ptr;
      rd_gray_ptr = exp_bin ^ (exp_bin >> 1);
    end
    w_enbl = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
